// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI4-Stream sink with patterned backpressure, packet framing capture and error flags
module axis_pkt_sink #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int BP_W      = 8
) (
  input  logic              c,
  input  logic              rn,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic [BP_W-1:0]   bp_pattern,
  input  logic              clr,
  output logic              pkt_done,
  output logic [15:0]       pkt_cnt,
  output logic [DATA_W-1:0] last_data,
  output logic [7:0]        last_len,
  output logic [DATA_W-1:0] last_csum,
  output logic              sof_err,
  output logic              user_err,
  output logic              len_err
);
  localparam int PTR_W = BP_W > 1 ? $clog2(BP_W) : 1;
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state, state_nx;
  logic [PTR_W-1:0] ptr;
  logic [7:0] beat_cnt, cnt_nx;
  logic [DATA_W-1:0] csum, csum_nx;
  logic acc, first, done;
  always_comb begin
    acc = s_axis_tvalid & s_axis_tready;
    first = state == IDLE;
    cnt_nx = first ? 8'd1 : (beat_cnt == 8'hFF ? 8'hFF : beat_cnt + 8'd1);
    csum_nx = first ? s_axis_tdata : csum ^ s_axis_tdata;
    done = acc & s_axis_tlast & ~clr;
    state_nx = clr ? IDLE : (acc ? (s_axis_tlast ? IDLE : IN_PKT) : state);
  end
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      ptr <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= bp_pattern[ptr];
      ptr <= ptr == PTR_W'(BP_W - 1) ? '0 : ptr + 1'b1;
    end
  end
  always_ff @(posedge c or negedge rn) begin
    if (!rn) state <= IDLE;
    else state <= state_nx;
  end
  // clr wins over a beat handshaked in the same cycle, so that beat is dropped
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      beat_cnt <= '0;
      csum <= '0;
      pkt_done <= 1'b0;
      pkt_cnt <= '0;
      last_data <= '0;
      last_len <= '0;
      last_csum <= '0;
      sof_err <= 1'b0;
      user_err <= 1'b0;
      len_err <= 1'b0;
    end else if (clr) begin
      beat_cnt <= '0;
      csum <= '0;
      pkt_done <= 1'b0;
      pkt_cnt <= '0;
      last_data <= '0;
      last_len <= '0;
      last_csum <= '0;
      sof_err <= 1'b0;
      user_err <= 1'b0;
      len_err <= 1'b0;
    end else begin
      pkt_done <= done;
      if (acc) begin
        beat_cnt <= cnt_nx;
        csum <= csum_nx;
        if (first && !s_axis_tuser) sof_err <= 1'b1;
        if (!first && s_axis_tuser) user_err <= 1'b1;
        if ({1'b0, cnt_nx} == 9'(MAX_BEATS + 1)) len_err <= 1'b1;
      end
      if (done) begin
        last_data <= s_axis_tdata;
        last_len <= cnt_nx;
        last_csum <= csum_nx;
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end
endmodule
